usart_tx_frame: RTL and testbench
=================================

Name: usart_tx_frame

Overview:
- UART transmitter, 8N1, LSB first. Companion to the design's 16x-oversampling UART receiver; drives its serial line.
- Takes a parallel byte on a single-cycle request and serialises it as: start bit, 8 data bits, stop bit.
- Baud rate is selected at run time from the same 5-rate table the receiver uses.
- Raises a one-cycle done pulse at end of frame, so a host can chain bytes back-to-back.

Parameters:
- CLK_FREQ_HZ, 50_000_000: system clock frequency. Each baud divisor is CLK_FREQ_HZ/baud with integer truncation.
- PARITY_ODD, 0: parity sense, used only with USART_TX_PARITY_EN. 0 = even, 1 = odd.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset_n  in  1  reset; synchronous, active-low.
- Baud_set  in  3  rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5..7=9600.
- Data  in  8  byte to send; sampled only when a request is accepted.
- Send_en  in  1  transmit request; single-cycle pulse or level.
- usart_tx  out  1  serial line; idle high; registered.
- Tx_busy  out  1  high while a frame is in progress.
- Tx_Done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low on Clk/Reset_n.
- Reset values: usart_tx=1, Tx_busy=0, Tx_Done=0. All counters, the shift register and the latched divisor are 0.
- Reset mid-frame: the line returns high on the next edge and the partial frame is abandoned. No Tx_Done is issued.
- Divisor table: DIV = CLK_FREQ_HZ/rate. At 50 MHz: 5208, 2604, 1302, 868, 434.
  - Baud counter is 13 bits and counts 0..DIV-1.
  - The divisor and Data are latched on request acceptance. Baud_set or Data changes mid-frame have no effect.
- States: IDLE, START, DATA, STOP.
- IDLE: usart_tx=1, Tx_busy=0.
  - Send_en=1 sampled at edge N: latch Data and DIV, go to START.
  - From edge N onward: Tx_busy=1 and usart_tx=0.
- START: hold 0 for exactly DIV cycles, then go to DATA with bit index 0.
- DATA: drive shift[0] for DIV cycles, then shift right and increment the 3-bit index. After index 7 completes, go to STOP.
- STOP: drive 1 for DIV cycles. On the last cycle, go to IDLE.
  - From the following edge: Tx_Done=1 for one cycle and Tx_busy=0.
- Frame timing: total frame is 10*DIV cycles. Every bit boundary is exact; there is no cumulative drift.
- Send_en while Tx_busy=1: ignored. It is not queued and the in-flight frame is unaffected.
- Back-to-back: Send_en in the same cycle Tx_Done=1 is accepted. The next start bit follows with no idle gap beyond the stop bit.
- Tx_Done is never asserted outside the end of a complete frame.

Optional Feature:
- Macro: USART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting DIV cycles.
  - Parity bit = XOR of the latched byte, inverted if PARITY_ODD=1.
  - Frame becomes 11*DIV cycles.
- Not defined: no PARITY state; PARITY_ODD is unused; frame is 10*DIV cycles (8N1).

Test Plan:
1. Reset held 5 cycles, then released, no Send_en -> usart_tx=1, Tx_busy=0, Tx_Done=0 for 1000 cycles.
2. Baud_set=4, Data=8'h55, Send_en pulse at edge N -> line shows 0,1,0,1,0,1,0,1,0,1, each level exactly 434 cycles. Tx_Done pulse at N+4340; Tx_busy low from the same edge.
3. Baud_set=0, Data=8'hA3, Baud_set changed to 4 at N+100 -> all bits stay 5208 cycles wide. Decoded LSB-first byte = 8'hA3.
4. Baud_set=4, Data=8'h0F, Send_en held high for 8000 cycles -> frame 1 = 0x0F. Frame 2 starts at the Tx_Done edge (N+4340) and sends 8'h0F. No extra frames from the held level inside either frame.
5. Second Send_en with Data=8'hFF at N+1000 during a frame -> ignored. The line completes the original byte and only one Tx_Done is seen.
6. Reset_n low for 1 cycle at N+2000 mid-frame -> usart_tx=1 and Tx_busy=0 from the next edge. No Tx_Done. A new request then sends correctly.
   - With USART_TX_PARITY_EN, Data=8'h07, PARITY_ODD=0: parity bit=1 and Tx_Done at N+4774.

Source files
------------

// File: rtl/usart_tx_frame.sv
// -----------------------------------------------------------------------------
// usart_tx_frame
//
// UART transmitter, LSB first. Serialises one byte per accepted request as
// start bit, 8 data bits, [parity bit], stop bit. The bit time is selected at
// run time from a 5-entry baud table and is latched together with the byte
// when the request is accepted, so later changes to Baud_set / Data cannot
// disturb a frame in flight.
//
// Build option:
//   USART_TX_PARITY_EN  when defined, a parity bit (even, or odd when
//                       PARITY_ODD=1) is sent between the data bits and the
//                       stop bit (8E1/8O1). When undefined the frame is 8N1.
//
// Parameters:
//   CLK_FREQ_HZ  system clock frequency; divisor = CLK_FREQ_HZ / baud
//   PARITY_ODD   0 = even parity, 1 = odd parity (parity builds only)
//
// Ports:
//   Clk       in   system clock, rising edge
//   Reset_n   in   synchronous active-low reset
//   Baud_set  in   0=9600 1=19200 2=38400 3=57600 4=115200 5..7=9600
//   Data      in   byte to send, sampled on request acceptance
//   Send_en   in   transmit request (pulse or level)
//   usart_tx  out  serial line, idle high, registered
//   Tx_busy   out  high while a frame is in progress
//   Tx_Done   out  one-cycle pulse after the stop bit completes
// -----------------------------------------------------------------------------
module usart_tx_frame #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int PARITY_ODD  = 0
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [2:0] Baud_set,
    input  logic [7:0] Data,
    input  logic       Send_en,
    output logic       usart_tx,
    output logic       Tx_busy,
    output logic       Tx_Done
);

    // The baud counter is 13 bits wide, so the slowest divisor must fit.
    if ((CLK_FREQ_HZ / 9600) > 8191 || (CLK_FREQ_HZ / 115200) < 1 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("usart_tx_frame: unsupported CLK_FREQ_HZ or PARITY_ODD");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef USART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    function automatic logic [12:0] baud_div(input logic [2:0] sel);
        case (sel)
            3'd1:    return 13'(CLK_FREQ_HZ / 19200);
            3'd2:    return 13'(CLK_FREQ_HZ / 38400);
            3'd3:    return 13'(CLK_FREQ_HZ / 57600);
            3'd4:    return 13'(CLK_FREQ_HZ / 115200);
            default: return 13'(CLK_FREQ_HZ / 9600);
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic [12:0] div_q, div_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef USART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    logic        bit_end;
    logic        accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef USART_TX_PARITY_EN
        par_d   = par_q;
`endif
        accept  = 1'b0;
        // Last cycle of the current bit: every bit is exactly div_q cycles,
        // the counter restarts at each boundary so there is no drift.
        bit_end = (cnt_q == div_q - 13'd1);

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
                accept = Send_en;
            end

            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
`ifdef USART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        // shift_q[1] is the bit that lands in shift[0] now
                        tx_d  = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end

`ifdef USART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
`endif

            S_STOP: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                    // A request on the final stop cycle chains the next
                    // start bit directly behind this stop bit.
                    accept  = Send_en;
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            state_d = S_START;
            cnt_d   = '0;
            idx_d   = '0;
            shift_d = Data;
            div_d   = baud_div(Baud_set);
            tx_d    = 1'b0;
            busy_d  = 1'b1;
`ifdef USART_TX_PARITY_EN
            par_d   = (^Data) ^ (PARITY_ODD != 0);
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef USART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef USART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign usart_tx = tx_q;
    assign Tx_busy  = busy_q;
    assign Tx_Done  = done_q;

endmodule

// File: tb/tb_usart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_usart_tx_frame
//
// Scoreboard bench for usart_tx_frame. The stimulus process pushes the byte
// and expected bit time of every frame it requests; an independent monitor
// waits for a start bit on the line, pops the expected frame, rebuilds the
// bit sequence from the byte and checks every bit level and width, the
// decoded byte, and the Tx_Done / Tx_busy behaviour at frame end.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_usart_tx_frame;

    localparam int CLK_HZ  = 50_000_000;
    localparam int PAR_ODD = 0;

    logic       Clk      = 1'b0;
    logic       Reset_n  = 1'b0;
    logic [2:0] Baud_set = 3'd0;
    logic [7:0] Data     = 8'h00;
    logic       Send_en  = 1'b0;
    logic       usart_tx;
    logic       Tx_busy;
    logic       Tx_Done;

    usart_tx_frame #(
        .CLK_FREQ_HZ(CLK_HZ),
        .PARITY_ODD (PAR_ODD)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Baud_set(Baud_set),
        .Data    (Data),
        .Send_en (Send_en),
        .usart_tx(usart_tx),
        .Tx_busy (Tx_busy),
        .Tx_Done (Tx_Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    frame_t exp_q[$];
    int compared   = 0;
    int mismatched = 0;
    int done_cnt   = 0;
    int exp_done   = 0;

    // Bit time in clocks for a rate selection.
    function automatic int ref_div(input logic [2:0] sel);
        int rates[5] = '{9600, 19200, 38400, 57600, 115200};
        if (sel > 3'd4) return CLK_HZ / 9600;
        return CLK_HZ / rates[sel];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (Tx_Done === 1'b1) done_cnt++;
    end

    // ------------------------------------------------------------------ monitor
    initial begin : monitor
        frame_t      f;
        logic [10:0] bits;
        logic [10:0] got;
        int          nb;
        int          bad_c;
        logic        bad_line;
        logic        bad_busy;
        bit          aborted;
        bit          pending;
        pending = 0;
        forever begin
            if (!pending) begin
                @(negedge Clk);
                if (usart_tx !== 1'b0 || Reset_n !== 1'b1) continue;
            end
            pending = 0;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_start: line low with no frame outstanding (t=%0t)", $time);
                while (usart_tx === 1'b0) @(negedge Clk);
                continue;
            end
            f = exp_q.pop_front();
            bits      = '0;
            got       = '0;
            bits[0]   = 1'b0;
            bits[8:1] = f.data;
`ifdef USART_TX_PARITY_EN
            bits[9]   = (^f.data) ^ (PAR_ODD != 0);
            bits[10]  = 1'b1;
            nb        = 11;
`else
            bits[9]   = 1'b1;
            nb        = 10;
`endif
            aborted = 0;
            for (int k = 0; k < nb && !aborted; k++) begin
                bad_c    = -1;
                bad_line = 1'b0;
                bad_busy = 1'b0;
                for (int c = 0; c < f.div; c++) begin
                    if (k != 0 || c != 0) @(negedge Clk);
                    if (Reset_n !== 1'b1) begin
                        aborted = 1;
                        break;
                    end
                    if (c == f.div / 2) got[k] = usart_tx;
                    if (bad_c < 0 && (usart_tx !== bits[k] || Tx_busy !== 1'b1)) begin
                        bad_c    = c;
                        bad_line = usart_tx;
                        bad_busy = Tx_busy;
                    end
                end
                if (!aborted) begin
                    compared++;
                    if (bad_c >= 0) begin
                        mismatched++;
                        $display("FAIL bit%0d: at cycle %0d of %0d line=%b busy=%b, expected line=%b busy=1 (t=%0t)",
                                 k, bad_c, f.div, bad_line, bad_busy, bits[k], $time);
                    end
                end
            end
            if (aborted) continue;
            check("frame_byte", {24'd0, got[8:1]}, {24'd0, f.data});
            @(negedge Clk);
            check("done_at_frame_end", {31'd0, Tx_Done}, 32'd1);
            if (usart_tx === 1'b0) begin
                check("busy_chained", {31'd0, Tx_busy}, 32'd1);
                pending = 1;
            end else begin
                check("busy_after_frame", {31'd0, Tx_busy}, 32'd0);
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic send(input logic [7:0] d, input logic [2:0] bs);
        frame_t f;
        @(posedge Clk);
        #1;
        Data     = d;
        Baud_set = bs;
        Send_en  = 1'b1;
        f.data   = d;
        f.div    = ref_div(bs);
        exp_q.push_back(f);
        exp_done++;
        @(posedge Clk);
        #1;
        Send_en = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int c;
        c = 0;
        while (done_cnt < exp_done && c < budget) begin
            @(posedge Clk);
            c++;
        end
        check(name, done_cnt, exp_done);
    endtask

    initial begin : stim
        int         bad;
        logic [7:0] d;

        // Reset held for 5 cycles; outputs checked while still in reset.
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset_tx",   {31'd0, usart_tx}, 32'd1);
        check("reset_busy", {31'd0, Tx_busy},  32'd0);
        check("reset_done", {31'd0, Tx_Done},  32'd0);
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        // Idle for 1000 cycles with no request.
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clk);
            if (usart_tx !== 1'b1 || Tx_busy !== 1'b0 || Tx_Done !== 1'b0) bad++;
        end
        check("idle_1000_bad_cycles", bad, 0);

        // 0x55 at 115200.
        send(8'h55, 3'd4);
        wait_done("t2_done", 6000);

        // 0xA3 at 9600, Baud_set and Data disturbed mid-frame.
        send(8'hA3, 3'd0);
        repeat (99) @(posedge Clk);
        #1;
        Baud_set = 3'd4;
        Data     = 8'h5A;
        wait_done("t3_done", 60000);

        // Send_en held high for 8000 cycles: exactly two chained frames.
        begin
            frame_t f;
            @(posedge Clk);
            #1;
            Data     = 8'h0F;
            Baud_set = 3'd4;
            Send_en  = 1'b1;
            f.data   = 8'h0F;
            f.div    = ref_div(3'd4);
            exp_q.push_back(f);
            exp_q.push_back(f);
            exp_done += 2;
            repeat (8000) @(posedge Clk);
            #1;
            Send_en = 1'b0;
        end
        wait_done("t4_done", 3000);

        // Request during a frame is ignored.
        d = 8'($urandom);
        send(d, 3'd4);
        repeat (999) @(posedge Clk);
        #1;
        Data    = 8'hFF;
        Send_en = 1'b1;
        @(posedge Clk);
        #1;
        Send_en = 1'b0;
        wait_done("t5_done", 6000);
        repeat (500) @(posedge Clk);
        check("t5_single_done", done_cnt, exp_done);

        // Reset mid-frame abandons the frame without Tx_Done.
        d = 8'($urandom);
        send(d, 3'd4);
        exp_done--;
        repeat (1999) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        check("t6_tx_after_reset",   {31'd0, usart_tx}, 32'd1);
        check("t6_busy_after_reset", {31'd0, Tx_busy},  32'd0);
        repeat (2500) @(posedge Clk);
        check("t6_no_done", done_cnt, exp_done);
        send(8'h07, 3'd4);
        wait_done("t6_resend_done", 6000);

        // Random byte at a random fast rate.
        d = 8'($urandom);
        send(d, 3'($urandom_range(3, 4)));
        wait_done("t7_done", 10000);

        repeat (20) @(posedge Clk);
        check("queue_drained", exp_q.size(), 0);
        check("final_done_count", done_cnt, exp_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached (t=%0t)", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
